// File: rtl/lcb_rx_pkg.sv
// Shared types for the LCB receive collector.
// Byte type, channel-index width helper and drain FSM states.
package lcb_rx_pkg;

   typedef logic [7:0] byte_t;

   localparam int SLOTS = 2;

   typedef enum logic [1:0] {
      IDLE,
      GRANT,
      READ,
      RELEASE
   } drain_state_t;

   function automatic int ch_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/lcb_rx_chan_buf.sv
// One LCB channel: ping-pong packet slots, overflow and inter-byte timeout.
// Ports: valid_i/data_i/clr_i byte input; rel_i per-slot release; rd_* read
// address; full_o/wr_slot_o slot state; q_o registered read data;
// ovf_o dropped-byte pulse; tmo_o timeout pulse.
module lcb_rx_chan_buf
   import lcb_rx_pkg::*;
#(
   parameter int BYTES   = 4,
   parameter int TIMEOUT = 800,
   localparam int AW = $clog2(BYTES),
   localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          valid_i,
   input  byte_t         data_i,
   input  logic          clr_i,
   input  logic [1:0]    rel_i,
   input  logic          rd_i,
   input  logic          rd_slot_i,
   input  logic [AW-1:0] rd_idx_i,
   output logic [1:0]    full_o,
   output logic          wr_slot_o,
   output byte_t         q_o,
   output logic          ovf_o,
   output logic          tmo_o
);

   logic [AW-1:0] idx_q, idx_d;
   logic          slot_q, slot_d;
   logic [1:0]    full_q, full_d;
   logic [TW-1:0] cnt_q, cnt_d;
   logic          ovf_q, ovf_d;
   logic          tmo_q, tmo_d;
   logic          we;
   byte_t         q_q;
   byte_t         mem_q [SLOTS][BYTES];

   always_comb begin
      idx_d  = idx_q;
      slot_d = slot_q;
      full_d = full_q & ~rel_i;
      cnt_d  = cnt_q;
      ovf_d  = 1'b0;
      tmo_d  = 1'b0;
      we     = 1'b0;
      if (clr_i) begin
         idx_d = '0;
         cnt_d = '0;
      end else if (valid_i) begin
         cnt_d = '0;
         // full_q, not full_d: a slot released this clock stays closed
         if (full_q[slot_q]) begin
            ovf_d = 1'b1;
         end else begin
            we = 1'b1;
            if (idx_q == AW'(BYTES - 1)) begin
               idx_d          = '0;
               full_d[slot_q] = 1'b1;
               slot_d         = ~slot_q;
            end else begin
               idx_d = idx_q + 1'b1;
            end
         end
      end else if (TIMEOUT != 0 && idx_q != '0
                   && cnt_q != TW'(TIMEOUT)) begin
         cnt_d = cnt_q + 1'b1;
         if (cnt_d == TW'(TIMEOUT)) begin
            idx_d = '0;
            tmo_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         idx_q  <= '0;
         slot_q <= 1'b0;
         full_q <= '0;
         cnt_q  <= '0;
         ovf_q  <= 1'b0;
         tmo_q  <= 1'b0;
         q_q    <= '0;
      end else begin
         idx_q  <= idx_d;
         slot_q <= slot_d;
         full_q <= full_d;
         cnt_q  <= cnt_d;
         ovf_q  <= ovf_d;
         tmo_q  <= tmo_d;
         if (rd_i) q_q <= mem_q[rd_slot_i][rd_idx_i];
      end
   end

   always_ff @(posedge clk) begin
      if (we) mem_q[slot_q][idx_q] <= data_i;
   end

   assign full_o    = full_q;
   assign wr_slot_o = slot_q;
   assign q_o       = q_q;
   assign ovf_o     = ovf_q;
   assign tmo_o     = tmo_q;

endmodule

// File: rtl/lcb_rx_collector.sv
// N-channel LCB receive collector: per-channel ping-pong packet capture,
// drained round-robin as a channel-tagged byte stream.
// Ports: i_valid/i_data/i_clr per-channel input; i_rd_en burst permit;
// o_strob/o_data/o_ch/o_sop/o_eop/o_busy drain stream; o_ovf sticky drop
// flags; o_tmo timeout pulses.
module lcb_rx_collector
   import lcb_rx_pkg::*;
#(
   parameter int N_CH    = 5,
   parameter int BYTES   = 4,
   parameter int TIMEOUT = 800,
   localparam int CHW = ch_w(N_CH),
   localparam int AW  = $clog2(BYTES)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [N_CH-1:0]   i_valid,
   input  logic [N_CH*8-1:0] i_data,
   input  logic [N_CH-1:0]   i_clr,
   input  logic              i_rd_en,
   output logic              o_strob,
   output logic [7:0]        o_data,
   output logic [CHW-1:0]    o_ch,
   output logic              o_sop,
   output logic              o_eop,
   output logic              o_busy,
   output logic [N_CH-1:0]   o_ovf,
   output logic [N_CH-1:0]   o_tmo
);

   drain_state_t   state_q;
   logic [CHW-1:0] ptr_q, ch_q, gnt;
   logic           slot_q, dslot;
   logic [AW-1:0]  ridx_q;
   logic           strob_q, sop_q, eop_q, busy_q;
   logic [N_CH-1:0] ovf_q, ovf_w, elig;
   logic [1:0]     full_w  [N_CH];
   logic           wslot_w [N_CH];
   byte_t          q_w     [N_CH];

   for (genvar k = 0; k < N_CH; k++) begin : g_ch
      logic [1:0] rel;
      logic       rd;
      assign rel = (state_q == RELEASE && ch_q == CHW'(k))
                 ? (slot_q ? 2'b10 : 2'b01) : 2'b00;
      assign rd = (state_q == READ) && (ch_q == CHW'(k));
      assign elig[k] = |full_w[k];
      lcb_rx_chan_buf #(
         .BYTES   (BYTES),
         .TIMEOUT (TIMEOUT)
      ) u_buf (
         .clk       (clk),
         .rst       (rst),
         .valid_i   (i_valid[k]),
         .data_i    (i_data[8*k +: 8]),
         .clr_i     (i_clr[k]),
         .rel_i     (rel),
         .rd_i      (rd),
         .rd_slot_i (slot_q),
         .rd_idx_i  (ridx_q),
         .full_o    (full_w[k]),
         .wr_slot_o (wslot_w[k]),
         .q_o       (q_w[k]),
         .ovf_o     (ovf_w[k]),
         .tmo_o     (o_tmo[k])
      );
   end

   // First eligible channel after the round-robin pointer, wrapping.
   always_comb begin
      int  c;
      logic found;
      c     = 0;
      found = 1'b0;
      gnt   = '0;
      for (int i = 1; i <= N_CH; i++) begin
         c = (int'(ptr_q) + i) % N_CH;
         if (!found && elig[c]) begin
            found = 1'b1;
            gnt   = CHW'(c);
         end
      end
   end

   // With both slots full the fill pointer has wrapped onto the older one.
   assign dslot = full_w[gnt][wslot_w[gnt]]
                ? wslot_w[gnt] : ~wslot_w[gnt];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= CHW'(N_CH - 1);
         ch_q    <= '0;
         slot_q  <= 1'b0;
         ridx_q  <= '0;
         strob_q <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         strob_q <= 1'b0;
         sop_q   <= 1'b0;
         eop_q   <= 1'b0;
         unique case (state_q)
            IDLE: begin
               if (i_rd_en && |elig) begin
                  state_q <= GRANT;
                  busy_q  <= 1'b1;
               end
            end
            GRANT: begin
               ch_q    <= gnt;
               ptr_q   <= gnt;
               slot_q  <= dslot;
               ridx_q  <= '0;
               state_q <= READ;
            end
            READ: begin
               strob_q <= 1'b1;
               sop_q   <= (ridx_q == '0);
               eop_q   <= (ridx_q == AW'(BYTES - 1));
               if (ridx_q == AW'(BYTES - 1)) begin
                  state_q <= RELEASE;
               end else begin
                  ridx_q <= ridx_q + 1'b1;
               end
            end
            RELEASE: begin
               state_q <= IDLE;
               busy_q  <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) ovf_q <= '0;
      else     ovf_q <= ovf_q | ovf_w;
   end

   assign o_strob = strob_q;
   assign o_data  = q_w[ch_q];
   assign o_ch    = ch_q;
   assign o_sop   = sop_q;
   assign o_eop   = eop_q;
   assign o_busy  = busy_q;
   assign o_ovf   = ovf_q;

endmodule
